// File: rtl/seq_pkg.sv
// Shared types and constants for the operand sequencer.
// State encoding, operand selects and datapath widths.
package seq_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 9;

    localparam logic [1:0] OP_A = 2'b00;
    localparam logic [1:0] OP_B = 2'b01;
    localparam logic [1:0] OP_C = 2'b10;
    localparam logic [1:0] OP_D = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAPW,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/operand_sequencer_cycle_counter.sv
// Clearable up-counter with a terminal-count compare.
// Used for the inter-capture gap and the valid timeout.
module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_at_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_terminal = (r_count == i_terminal);

endmodule

// File: rtl/operand_sequencer.sv
// Serialises a four-operand packet onto the datapath load port,
// then waits (bounded) for the datapath result and returns it.
module operand_sequencer
    import seq_pkg::*;
#(
    parameter int GAP            = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [OPND_W-1:0] op_a,
    input  logic [OPND_W-1:0] op_b,
    input  logic [OPND_W-1:0] op_c,
    input  logic [OPND_W-1:0] op_d,
    output logic              ready,
    output logic              capture,
    output logic [1:0]        op,
    output logic [OPND_W-1:0] d_out,
    input  logic              valid_in,
    input  logic [RES_W-1:0]  result_in,
    output logic              done,
    output logic              err,
    output logic [RES_W-1:0]  result
);

    localparam logic [3:0] GAP_TC = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [7:0] TO_TC  = 8'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [OPND_W-1:0] r_opnd [4];
    logic [1:0]        r_op;
    logic [OPND_W-1:0] r_d_out;
    logic              r_err;
    logic [RES_W-1:0]  r_result;
    logic              w_last;
    logic [1:0]        w_nxt_op;
    logic              w_advance;
    logic              w_gap_tc;
    logic              w_to_tc;

    assign w_last    = (r_op == OP_D);
    assign w_nxt_op  = r_op + 2'd1;
    assign w_advance = ((r_state == S_SEND) && !w_last && (GAP == 0))
                    || ((r_state == S_GAPW) && w_gap_tc);

    cycle_counter #(.WIDTH(4)) u_gap_cnt (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_clear       (r_state != S_GAPW),
        .i_enable      (r_state == S_GAPW),
        .i_terminal    (GAP_TC),
        .o_at_terminal (w_gap_tc)
    );

    cycle_counter #(.WIDTH(8)) u_to_cnt (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_clear       (r_state != S_WAIT),
        .i_enable      (r_state == S_WAIT),
        .i_terminal    (TO_TC),
        .o_at_terminal (w_to_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_SEND;
            S_SEND: begin
                if (w_last)       w_next = S_WAIT;
                else if (GAP > 0) w_next = S_GAPW;
            end
            S_GAPW: if (w_gap_tc) w_next = S_SEND;
            // A valid in the final wait cycle beats the timeout
            S_WAIT: if (valid_in || w_to_tc) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= OP_A;
            r_d_out  <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_opnd[0] <= op_a;
                r_opnd[1] <= op_b;
                r_opnd[2] <= op_c;
                r_opnd[3] <= op_d;
                r_op      <= OP_A;
                r_d_out   <= op_a;
            end
            if (w_advance) begin
                r_op    <= w_nxt_op;
                r_d_out <= r_opnd[w_nxt_op];
            end
            if (r_state == S_WAIT) begin
                if (valid_in) begin
                    r_result <= result_in;
                    r_err    <= 1'b0;
                end else if (w_to_tc) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign capture = (r_state == S_SEND);
    assign done    = (r_state == S_DONE);
    assign op      = r_op;
    assign d_out   = r_d_out;
    assign err     = r_err;
    assign result  = r_result;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: GAP=0 and GAP=2 instances, each
// driving a behavioural datapath; checked against a timing model.
module tb_operand_sequencer;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] op_a, op_b, op_c, op_d;
    logic       start_s;
    int         sel;
    logic       dp_en, inj_v;
    logic [8:0] inj_r;

    logic       start0, rdy0, cap0, done0, err0, vin0;
    logic [1:0] op0;
    logic [7:0] dout0;
    logic [8:0] res0, rin0;
    logic       start2, rdy2, cap2, done2, err2, vin2;
    logic [1:0] op2;
    logic [7:0] dout2;
    logic [8:0] res2, rin2;

    logic [7:0] dpr0 [4];
    logic [7:0] dpr2 [4];
    logic       pend0, dval0, pend2, dval2;
    logic [8:0] dres0, dres2;

    logic       v_rdy, v_cap, v_done, v_err;
    logic [1:0] v_op;
    logic [7:0] v_dout;
    logic [8:0] v_res;

    logic [8:0] prev_res [2];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign start0 = start_s && (sel == 0);
    assign start2 = start_s && (sel == 1);
    assign vin0 = (dp_en && dval0) || (inj_v && sel == 0);
    assign vin2 = (dp_en && dval2) || (inj_v && sel == 1);
    assign rin0 = (inj_v && sel == 0) ? inj_r : dres0;
    assign rin2 = (inj_v && sel == 1) ? inj_r : dres2;

    assign v_rdy  = sel ? rdy2  : rdy0;
    assign v_cap  = sel ? cap2  : cap0;
    assign v_done = sel ? done2 : done0;
    assign v_err  = sel ? err2  : err0;
    assign v_op   = sel ? op2   : op0;
    assign v_dout = sel ? dout2 : dout0;
    assign v_res  = sel ? res2  : res0;

    operand_sequencer #(.GAP(0), .TIMEOUT_CYCLES(TO)) u0 (
        .clock(clk), .reset(reset), .start(start0),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .ready(rdy0), .capture(cap0), .op(op0), .d_out(dout0),
        .valid_in(vin0), .result_in(rin0),
        .done(done0), .err(err0), .result(res0)
    );

    operand_sequencer #(.GAP(2), .TIMEOUT_CYCLES(TO)) u2 (
        .clock(clk), .reset(reset), .start(start2),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .ready(rdy2), .capture(cap2), .op(op2), .d_out(dout2),
        .valid_in(vin2), .result_in(rin2),
        .done(done2), .err(err2), .result(res2)
    );

    // Datapath: load on capture, valid one cycle after D is loaded
    always @(posedge clk) begin
        if (reset) begin
            pend0 <= 1'b0;
            dval0 <= 1'b0;
        end else begin
            pend0 <= cap0 && (op0 == 2'd3);
            dval0 <= pend0;
            if (cap0) dpr0[op0] <= dout0;
            if (pend0)
                dres0 <= 9'({1'b0, dpr0[0]} + {1'b0, dpr0[1]}
                           - {1'b0, dpr0[2]} - {1'b0, dpr0[3]});
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            pend2 <= 1'b0;
            dval2 <= 1'b0;
        end else begin
            pend2 <= cap2 && (op2 == 2'd3);
            dval2 <= pend2;
            if (cap2) dpr2[op2] <= dout2;
            if (pend2)
                dres2 <= 9'({1'b0, dpr2[0]} + {1'b0, dpr2[1]}
                           - {1'b0, dpr2[2]} - {1'b0, dpr2[3]});
        end
    end

    function automatic logic [8:0] exp_sum(input int a, b, c, d);
        int s;
        s = a + b - c - d;
        s = ((s % 512) + 512) % 512;
        return 9'(s);
    endfunction

    task automatic run_txn(input string nm, input int g,
                           input logic [7:0] a, b, c, d,
                           input bit dp_on, input int inj_c,
                           input logic [8:0] inj_val, input int stray_c);
        int win_lo, win_hi, exp_done, ncap, ndone;
        bit exp_err;
        logic [8:0] exp_res;
        logic [7:0] opnd [4];
        opnd = '{a, b, c, d};
        win_lo = 5 + 3 * g;
        win_hi = win_lo + TO - 1;
        if (dp_on) begin
            exp_done = 7 + 3 * g;
            exp_err = 1'b0;
            exp_res = exp_sum(a, b, c, d);
        end else if (inj_c >= win_lo && inj_c <= win_hi) begin
            exp_done = inj_c + 1;
            exp_err = 1'b0;
            exp_res = inj_val;
        end else begin
            exp_done = win_hi + 1;
            exp_err = 1'b1;
            exp_res = prev_res[sel];
        end
        dp_en = dp_on;
        inj_r = inj_val;
        @(negedge clk);
        n_chk++;
        if (v_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: got %b want 1", nm, v_rdy);
        end
        op_a = a; op_b = b; op_c = c; op_d = d;
        start_s = 1'b1;
        ncap = 0;
        ndone = 0;
        for (int cy = 1; cy <= exp_done + 6; cy++) begin
            @(posedge clk);
            #1;
            start_s = (cy == stray_c);
            inj_v = (cy == inj_c);
            op_a = 8'($urandom); op_b = 8'($urandom);
            op_c = 8'($urandom); op_d = 8'($urandom);
            @(negedge clk);
            if (cy == stray_c) begin
                n_chk++;
                if (v_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ready_busy: got %b want 0", nm, v_rdy);
                end
            end
            if (v_cap) begin
                n_chk++;
                if (ncap >= 4) begin
                    n_fail++;
                    $display("FAIL %s extra_capture: got cycle %0d want none", nm, cy);
                end else if (cy != 1 + ncap * (g + 1) || v_op !== 2'(ncap)
                             || v_dout !== opnd[ncap]) begin
                    n_fail++;
                    $display("FAIL %s capture%0d: got cyc %0d op %0d d %0h want cyc %0d op %0d d %0h",
                             nm, ncap, cy, v_op, v_dout, 1 + ncap * (g + 1), ncap, opnd[ncap]);
                end
                ncap++;
            end else if (g > 0 && ncap > 0 && ncap < 4) begin
                n_chk++;
                if (v_op !== 2'(ncap - 1) || v_dout !== opnd[ncap - 1]) begin
                    n_fail++;
                    $display("FAIL %s gap_hold: got op %0d d %0h want op %0d d %0h",
                             nm, v_op, v_dout, ncap - 1, opnd[ncap - 1]);
                end
            end
            if (v_done) begin
                ndone++;
                n_chk++;
                if (cy != exp_done || v_err !== exp_err || v_res !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s done: got cyc %0d err %b res %h want cyc %0d err %b res %h",
                             nm, cy, v_err, v_res, exp_done, exp_err, exp_res);
                end
            end
            if (cy == exp_done + 1) begin
                n_chk++;
                if (v_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s ready_after: got %b want 1", nm, v_rdy);
                end
            end
        end
        start_s = 1'b0;
        inj_v = 1'b0;
        n_chk++;
        if (ncap != 4 || ndone != 1) begin
            n_fail++;
            $display("FAIL %s counts: got caps %0d dones %0d want 4 1", nm, ncap, ndone);
        end
        if (!exp_err) prev_res[sel] = exp_res;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #0;
            n_chk++;
            if (v_rdy !== 1'b1 || v_cap !== 1'b0 || v_done !== 1'b0 || v_err !== 1'b0
                || v_res !== 9'h0 || v_op !== 2'b00 || v_dout !== 8'h0) begin
                n_fail++;
                $display("FAIL reset%0d: got rdy %b cap %b done %b err %b res %h op %0d d %h want 1 0 0 0 0 0 0",
                         i, v_rdy, v_cap, v_done, v_err, v_res, v_op, v_dout);
            end
        end
        sel = 0;
        prev_res[0] = 9'h0;
        prev_res[1] = 9'h0;
    endtask

    task automatic test_basic();
        sel = 0;
        run_txn("basic", 0, 8'd10, 8'd20, 8'd5, 8'd3, 1'b1, -1, 9'h0, -1);
        n_chk++;
        if (prev_res[0] !== 9'h016) begin
            n_fail++;
            $display("FAIL basic_model: got %h want 016", prev_res[0]);
        end
    endtask

    task automatic test_corners();
        sel = 0;
        run_txn("max", 0, 8'd255, 8'd255, 8'd0, 8'd0, 1'b1, -1, 9'h0, -1);
        run_txn("wrap", 0, 8'd0, 8'd0, 8'd255, 8'd255, 1'b1, -1, 9'h0, -1);
    endtask

    task automatic test_gap();
        sel = 1;
        run_txn("gap2", 2, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, -1, 9'h0, -1);
        sel = 0;
    endtask

    task automatic test_timeout();
        sel = 0;
        run_txn("timeout", 0, 8'd7, 8'd8, 8'd9, 8'd10, 1'b0, -1, 9'h0, -1);
    endtask

    task automatic test_valid_wins();
        sel = 0;
        run_txn("valid_last", 0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 19, 9'h155, -1);
    endtask

    task automatic test_stale_valid();
        sel = 0;
        run_txn("stale_valid", 0, 8'd3, 8'd3, 8'd3, 8'd3, 1'b0, 2, 9'h0AA, -1);
    endtask

    task automatic test_stray_start();
        sel = 0;
        run_txn("stray", 0, 8'd40, 8'd2, 8'd9, 8'd1, 1'b1, -1, 9'h0, 2);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        dp_en = 1'b1;
        @(negedge clk);
        op_a = 8'd50; op_b = 8'd60; op_c = 8'd70; op_d = 8'd80;
        start_s = 1'b1;
        for (int cy = 1; cy <= 3; cy++) begin
            @(posedge clk);
            #1;
            start_s = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (v_rdy !== 1'b1 || v_cap !== 1'b0 || v_done !== 1'b0 || v_res !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy %b cap %b done %b res %h want 1 0 0 000",
                     v_rdy, v_cap, v_done, v_res);
        end
        prev_res[0] = 9'h0;
        prev_res[1] = 9'h0;
        run_txn("after_reset", 0, 8'd100, 8'd27, 8'd13, 8'd4, 1'b1, -1, 9'h0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            sel = i % 2;
            run_txn("random", sel ? 2 : 0, 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 1'b1, -1, 9'h0, -1);
        end
        sel = 0;
    endtask

    initial begin
        reset = 1'b1;
        sel = 0;
        start_s = 1'b0;
        dp_en = 1'b1;
        inj_v = 1'b0;
        inj_r = 9'h0;
        op_a = 8'h0; op_b = 8'h0; op_c = 8'h0; op_d = 8'h0;
        test_reset();
        test_basic();
        test_corners();
        test_gap();
        test_timeout();
        test_valid_wins();
        test_stale_valid();
        test_stray_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
